// File: rtl/comb_sched.sv
// comb_sched: sequencer for one feedback comb filter built on an external
// circular-buffer BRAM and one external pipelined multiplier.
// After reset the whole delay line is zeroed, then samples are accepted one at a time.
// A sample is either passed straight through (bypass) or processed on the
// comb path:
//   - read the delayed tap
//   - issue three products (feedback, wet, dry)
//   - write x + feedback back into the line
//   - emit wet + dry
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cf_en, delay_len,
//   fb_gain, mix              per-sample controls, latched at accept
//   sample_valid/ready/in     input sample handshake (ready only in IDLE)
//   out_valid, out_sample     one-cycle output strobe and data
//   ram_rd_*, ram_wr_*        BRAM read/write ports (read latency RAM_LAT)
//   mul_en, mul_a, mul_b, mul_p  multiplier issue and product (latency MULT_LAT)
module comb_sched #(
  parameter int ADDR_W   = 12,
  parameter int RAM_LAT  = 2,
  parameter int MULT_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cf_en,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [15:0]       fb_gain,
  input  logic [15:0]       mix,
  input  logic              sample_valid,
  input  logic [15:0]       sample_in,
  output logic              sample_ready,
  output logic              out_valid,
  output logic [15:0]       out_sample,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [15:0]       ram_rd_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [15:0]       ram_wr_data,
  output logic              mul_en,
  output logic [15:0]       mul_a,
  output logic [15:0]       mul_b,
  input  logic [31:0]       mul_p
);

  // vld_pipe[k] is high during cycle T+1+k of an active sample
  localparam int STAGES = 4 + RAM_LAT + MULT_LAT;
  localparam int K_CAP  = RAM_LAT;              // tap data present on ram_rd_data
  localparam int K_FBP  = 1 + RAM_LAT + MULT_LAT; // feedback product on mul_p
  localparam int K_WETP = K_FBP + 1;
  localparam int K_DRYP = K_FBP + 2;            // last product; WB registered here

  typedef enum logic [2:0] {S_CLEAR, S_CLR_LAST, S_IDLE, S_BYP, S_ACT} state_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] fb;
    logic [15:0] mix;
  } ctx_t;

  state_t            state;
  ctx_t              ctx;
  logic [STAGES:0]   vld_pipe;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [15:0]       tap;
  logic [15:0]       fb_p;
  logic [15:0]       wet_p;
  logic [ADDR_W-1:0] dsel;
  logic [15:0]       p_scaled;
  logic              accept_act;

  function automatic logic [15:0] sat16(input logic signed [16:0] s);
    if (s > 17'sd32767)       return 16'h7FFF;
    else if (s < -17'sd32768) return 16'h8000;
    else                      return s[15:0];
  endfunction

  assign sample_ready = (state == S_IDLE);
  assign accept_act   = (state == S_IDLE) && sample_valid && cf_en;
  // a zero delay would read the slot about to be written; treat it as one
  assign dsel         = (delay_len == '0) ? ADDR_W'(1) : delay_len;
  // Q1.15 x Q1.15 -> Q1.15, keeping the low 16 bits of the shifted product
  assign p_scaled     = 16'($signed(mul_p) >>> 15);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CLEAR;
      ctx         <= '0;
      vld_pipe    <= '0;
      clr_cnt     <= '0;
      wr_ptr      <= '0;
      tap         <= '0;
      fb_p        <= '0;
      wet_p       <= '0;
      out_valid   <= 1'b0;
      out_sample  <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      mul_en      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      // strobes default low; addresses and operands hold
      out_valid <= 1'b0;
      ram_rd_en <= 1'b0;
      ram_wr_en <= 1'b0;
      mul_en    <= 1'b0;
      vld_pipe  <= {vld_pipe[STAGES-1:0], accept_act};

      case (state)
        S_CLEAR: begin
          ram_wr_en   <= 1'b1;
          ram_wr_addr <= clr_cnt;
          ram_wr_data <= '0;
          clr_cnt     <= clr_cnt + 1'b1;
          if (clr_cnt == {ADDR_W{1'b1}}) state <= S_CLR_LAST;
        end
        // last clear write is on the bus this cycle
        S_CLR_LAST: state <= S_IDLE;
        S_IDLE: begin
          if (sample_valid) begin
            ctx <= '{x: sample_in, fb: fb_gain, mix: mix};
            if (cf_en) begin
              ram_rd_en   <= 1'b1;
              ram_rd_addr <= wr_ptr - dsel;
              state       <= S_ACT;
            end else begin
              out_valid  <= 1'b1;
              out_sample <= sample_in;
              state      <= S_BYP;
            end
          end
        end
        S_BYP: state <= S_IDLE;
        S_ACT: begin
          if (vld_pipe[K_CAP]) begin
            tap    <= ram_rd_data;
            mul_en <= 1'b1;
            mul_a  <= ram_rd_data;
            mul_b  <= ctx.fb;
          end
          if (vld_pipe[K_CAP+1]) begin
            mul_en <= 1'b1;
            mul_a  <= tap;
            mul_b  <= ctx.mix;
          end
          if (vld_pipe[K_CAP+2]) begin
            mul_en <= 1'b1;
            mul_a  <= ctx.x;
            mul_b  <= 16'h7FFF - ctx.mix;
          end
          if (vld_pipe[K_FBP])  fb_p  <= p_scaled;
          if (vld_pipe[K_WETP]) wet_p <= p_scaled;
          if (vld_pipe[K_DRYP]) begin
            ram_wr_en   <= 1'b1;
            ram_wr_addr <= wr_ptr;
            ram_wr_data <= sat16($signed({ctx.x[15], ctx.x}) + $signed({fb_p[15], fb_p}));
            out_valid   <= 1'b1;
            out_sample  <= sat16($signed({wet_p[15], wet_p}) + $signed({p_scaled[15], p_scaled}));
            wr_ptr      <= wr_ptr + 1'b1;
          end
          if (vld_pipe[STAGES]) state <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_sched.sv
module tb_comb_sched;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int LAT = 9;

  logic clk = 0, rst = 1;
  logic cf_en = 0, sample_valid = 0;
  logic [AW-1:0] delay_len = '0;
  logic [15:0] fb_gain = '0, mix = '0, sample_in = '0;
  logic sample_ready, out_valid, ram_rd_en, ram_wr_en, mul_en;
  logic [15:0] out_sample, ram_rd_data, ram_wr_data, mul_a, mul_b;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic [31:0] mul_p;

  always #5 clk = ~clk;

  comb_sched #(.ADDR_W(AW), .RAM_LAT(2), .MULT_LAT(2)) dut (
    .clk(clk), .rst(rst), .cf_en(cf_en), .delay_len(delay_len),
    .fb_gain(fb_gain), .mix(mix), .sample_valid(sample_valid),
    .sample_in(sample_in), .sample_ready(sample_ready),
    .out_valid(out_valid), .out_sample(out_sample),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p));

  // external primitives: 2-cycle BRAM, 2-cycle multiplier
  logic [15:0] mem [DEPTH];
  logic [15:0] rd1;
  logic signed [31:0] m1;
  always @(posedge clk) begin
    if (ram_rd_en) rd1 <= mem[ram_rd_addr];
    ram_rd_data <= rd1;
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (mul_en) m1 <= $signed(mul_a) * $signed(mul_b);
    mul_p <= m1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // behavioural model: delay line as an int array, Q1.15 math on ints
  typedef struct {
    int t; bit byp; int ra; int d; int x; int fb; int mix; int out; int wa; int wd;
  } exp_t;
  exp_t q[$];
  int dl [DEPTH];
  int wp = 0;
  int outs[$], wrs[$], rds[$];
  bit chk_on = 0;

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction
  function automatic int s16(input int v);
    int r = v & 'hFFFF;
    return (r > 32767) ? r - 65536 : r;
  endfunction
  function automatic int sc(input int a, input int b);
    int p = a * b;
    return s16(p >>> 15);
  endfunction

  task automatic model_accept(input int x, input bit en, input int dly, input int fb, input int mx, input int t);
    exp_t e;
    int d;
    e.t = t; e.byp = !en; e.x = s16(x); e.fb = s16(fb); e.mix = mx;
    if (!en) begin
      e.out = e.x;
    end else begin
      d = (dly == 0) ? 1 : dly;
      e.ra = (wp - d + DEPTH) % DEPTH;
      e.d = dl[e.ra];
      e.wa = wp;
      e.wd = sat(e.x + sc(e.d, e.fb));
      e.out = sat(sc(e.d, mx) + sc(e.x, 32767 - mx));
      dl[wp] = e.wd;
      wp = (wp + 1) % DEPTH;
    end
    q.push_back(e);
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      if (out_valid) outs.push_back(int'(out_sample));
      if (ram_wr_en) wrs.push_back(int'(ram_wr_data));
      if (ram_rd_en) rds.push_back(int'(ram_rd_addr));
      if (q.size() > 0 && cyc > q[0].t) begin
        automatic exp_t e = q[0];
        automatic int k = cyc - e.t;
        chk("busy_ready", sample_ready, 0);
        if (e.byp) begin
          chk("byp_valid", out_valid, 1);
          chk("byp_out", out_sample, e.out & 'hFFFF);
          chk("byp_quiet", {ram_rd_en, ram_wr_en, mul_en}, 0);
          void'(q.pop_front());
        end else begin
          chk("rd_en", ram_rd_en, (k == 1) ? 1 : 0);
          if (k == 1) chk("rd_addr", ram_rd_addr, e.ra);
          chk("mul_en", mul_en, (k >= 4 && k <= 6) ? 1 : 0);
          if (k == 4) begin chk("mul_a_fb", mul_a, e.d & 'hFFFF); chk("mul_b_fb", mul_b, e.fb & 'hFFFF); end
          if (k == 5) begin chk("mul_a_wet", mul_a, e.d & 'hFFFF); chk("mul_b_wet", mul_b, e.mix); end
          if (k == 6) begin chk("mul_a_dry", mul_a, e.x & 'hFFFF); chk("mul_b_dry", mul_b, 32767 - e.mix); end
          if (k == LAT) begin
            chk("out_valid", out_valid, 1);
            chk("out_sample", out_sample, e.out & 'hFFFF);
            chk("wr_en", ram_wr_en, 1);
            chk("wr_addr", ram_wr_addr, e.wa);
            chk("wr_data", ram_wr_data, e.wd & 'hFFFF);
            void'(q.pop_front());
          end else begin
            chk("early_out", {out_valid, ram_wr_en}, 0);
          end
        end
      end else if (q.size() == 0) begin
        chk("idle_quiet", {out_valid, ram_rd_en, ram_wr_en, mul_en}, 0);
      end
    end
  end

  task automatic do_reset();
    int cnt = 0, last = -10, nov = 0;
    chk_on = 0;
    rst = 1;
    q.delete();
    wp = 0;
    for (int i = 0; i < DEPTH; i++) dl[i] = 0;
    @(negedge clk);
    chk("rst_outs", {out_valid, sample_ready, ram_wr_en, ram_rd_en, mul_en}, 0);
    chk("rst_data", {out_sample, mul_a, mul_b}, 0);
    rst = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) nov++;
      if (ram_wr_en) begin
        chk("clr_addr", ram_wr_addr, cnt & (DEPTH - 1));
        chk("clr_data", ram_wr_data, 0);
        cnt++;
        last = cyc;
      end
      if (sample_ready) break;
    end
    chk("clr_count", cnt, DEPTH);
    chk("clr_ready", sample_ready, 1);
    chk("ready_rise", cyc, last + 1);
    chk("no_out_in_clr", nov, 0);
    chk_on = 1;
  endtask

  task automatic send(input int x, input bit en, input int dly, input int fb, input int mx);
    int n = 0;
    while (!sample_ready && n < 50) begin @(negedge clk); n++; end
    if (!sample_ready) begin chk("ready_timeout", 0, 1); return; end
    sample_valid = 1; sample_in = 16'(x); cf_en = en;
    delay_len = AW'(dly); fb_gain = 16'(fb); mix = 16'(mx);
    model_accept(x, en, dly, fb, mx, cyc);
    @(negedge clk);
    // scramble controls so a sample that re-reads them mid-flight shows up
    sample_valid = 0; cf_en = !en; delay_len = 4'd7; fb_gain = 16'h1234; mix = 16'h0100;
  endtask

  task automatic poke();
    @(negedge clk);
    sample_valid = 1; sample_in = 16'h7777;
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // impulse, delay 4, no feedback, 50% wet
    outs.delete();
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 'h4000 : 0, 1, 4, 0, 'h4000);
      if (i == 1) poke();
    end
    drain();
    chk("t2_count", outs.size(), 8);
    chk("t2_out0", outs[0], 'h1FFF);
    chk("t2_out1", outs[1], 0);
    chk("t2_out4", outs[4], 'h2000);
    chk("t2_out5", outs[5], 0);

    // feedback 0.5, delay 2, fully wet
    outs.delete(); wrs.delete();
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 'h4000 : 0, 1, 2, 'h4000, 'h7FFF);
      if (i == 3) poke();
    end
    drain();
    chk("t3_out2", outs[2], 'h3FFF);
    chk("t3_out4", outs[4], 'h1FFF);
    chk("t3_out6", outs[6], 'h0FFF);
    chk("t3_wr0", wrs[0], 'h4000);
    chk("t3_wr1", wrs[1], 0);
    chk("t3_wr2", wrs[2], 'h2000);
    chk("t3_wr4", wrs[4], 'h1000);

    // saturating feedback; later samples use delay 0 (acts as 1)
    do_reset();
    wrs.delete();
    for (int i = 0; i < 8; i++) send('h7FFF, 1, (i < 4) ? 1 : 0, 'h7FFF, 'h4000);
    drain();
    chk("t4_count", wrs.size(), 8);
    foreach (wrs[i]) chk("t4_sat", wrs[i], 'h7FFF);

    // bypass, then an active sample to confirm wr_ptr did not move
    outs.delete();
    send('h8001, 0, 3, 'h4000, 'h2000);
    drain();
    chk("t5_byp", outs[0], 'h8001);
    send('h0100, 1, 1, 'h4000, 'h4000);
    drain();

    // reset in the middle of the multiply phase
    send('h1234, 1, 5, 'h3000, 'h2000);
    repeat (4) @(negedge clk);
    do_reset();
    rds.delete();
    send('h0100, 1, 3, 'h2000, 'h3000);
    drain();
    chk("t6_rd_addr", rds[0], 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
